// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port burst arbiter: FSM state encoding and port index.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

    // Port 1 is "last served" out of reset so that port 0 wins the first round.
    localparam port_idx_t RESET_LAST_PORT = PORT1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational next-grant selector for mem_burst_arbiter.
// Build option: define MEM_ARB_FIXED_PRIO_EN to give port 0 absolute priority;
// otherwise ports alternate round-robin based on last_port.
// Within the chosen port a pending write is served before a pending read.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic      p0_rd_req,
    input  logic      p0_wr_req,
    input  logic      p1_rd_req,
    input  logic      p1_wr_req,
    input  port_idx_t last_port,
    output logic      any_req,
    output port_idx_t pick_port,
    output logic      pick_is_wr
);

    logic p0_any;
    logic p1_any;

    assign p0_any  = p0_rd_req | p0_wr_req;
    assign p1_any  = p1_rd_req | p1_wr_req;
    assign any_req = p0_any | p1_any;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // History is irrelevant under fixed priority.
    logic unused_last_port;
    assign unused_last_port = last_port;

    // Port 0 wins whenever it has anything pending.
    always_comb begin
        pick_port = p0_any ? PORT0 : PORT1;
    end
`else
    // The port that was not served last wins if it is asking; otherwise the other one.
    always_comb begin
        if (last_port == PORT0) begin
            pick_port = p1_any ? PORT1 : PORT0;
        end else begin
            pick_port = p0_any ? PORT0 : PORT1;
        end
    end
`endif

    // Writes beat reads inside the selected port.
    always_comb begin
        pick_is_wr = (pick_port == PORT1) ? p1_wr_req : p0_wr_req;
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Two-port burst arbiter in front of the DDR3 burst adapter.
// Grants one whole burst at a time, steers request/address/length/data down
// from the granted port and routes data strobes and finish pulses back to it.
// Build option: MEM_ARB_FIXED_PRIO_EN (handled inside mem_arb_pick).
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_DATA_BITS = 512,
    parameter int ADDR_BITS     = 28,
    parameter int LEN_BITS      = 10
) (
    input  logic                     mem_clk,
    input  logic                     rst,

    // Port 0
    input  logic                     p0_rd_burst_req,
    input  logic                     p0_wr_burst_req,
    input  logic [LEN_BITS-1:0]      p0_rd_burst_len,
    input  logic [LEN_BITS-1:0]      p0_wr_burst_len,
    input  logic [ADDR_BITS-1:0]     p0_rd_burst_addr,
    input  logic [ADDR_BITS-1:0]     p0_wr_burst_addr,
    input  logic [MEM_DATA_BITS-1:0] p0_wr_burst_data,
    output logic                     p0_wr_burst_data_req,
    output logic                     p0_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] p0_rd_burst_data,
    output logic                     p0_rd_burst_finish,
    output logic                     p0_wr_burst_finish,

    // Port 1
    input  logic                     p1_rd_burst_req,
    input  logic                     p1_wr_burst_req,
    input  logic [LEN_BITS-1:0]      p1_rd_burst_len,
    input  logic [LEN_BITS-1:0]      p1_wr_burst_len,
    input  logic [ADDR_BITS-1:0]     p1_rd_burst_addr,
    input  logic [ADDR_BITS-1:0]     p1_wr_burst_addr,
    input  logic [MEM_DATA_BITS-1:0] p1_wr_burst_data,
    output logic                     p1_wr_burst_data_req,
    output logic                     p1_rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] p1_rd_burst_data,
    output logic                     p1_rd_burst_finish,
    output logic                     p1_wr_burst_finish,

    // Downstream burst adapter
    output logic                     rd_burst_req,
    output logic                     wr_burst_req,
    output logic [LEN_BITS-1:0]      rd_burst_len,
    output logic [LEN_BITS-1:0]      wr_burst_len,
    output logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data,
    input  logic                     rd_burst_data_valid,
    input  logic                     wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic                     rd_burst_finish,
    input  logic                     wr_burst_finish,

    // Status
    output logic                     grant_port,
    output logic                     busy
);

    arb_state_t state_q, state_d;
    port_idx_t  grant_port_q, grant_port_d;
    logic       grant_is_wr_q, grant_is_wr_d;
    port_idx_t  last_port_q, last_port_d;
    logic       rd_req_q, rd_req_d;
    logic       wr_req_q, wr_req_d;

    logic       any_req;
    port_idx_t  pick_port;
    logic       pick_is_wr;
    logic       busy_int;
    logic       grant_done;
    logic [1:0] rd_sel;
    logic [1:0] wr_sel;

    mem_arb_pick u_pick (
        .p0_rd_req  (p0_rd_burst_req),
        .p0_wr_req  (p0_wr_burst_req),
        .p1_rd_req  (p1_rd_burst_req),
        .p1_wr_req  (p1_wr_burst_req),
        .last_port  (last_port_q),
        .any_req    (any_req),
        .pick_port  (pick_port),
        .pick_is_wr (pick_is_wr)
    );

    // Only the finish that matches the granted direction ends the burst.
    assign grant_done = grant_is_wr_q ? wr_burst_finish : rd_burst_finish;

    // State and grant registers; reset abandons any burst in flight.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_port_q  <= PORT0;
            grant_is_wr_q <= 1'b0;
            last_port_q   <= RESET_LAST_PORT;
            rd_req_q      <= 1'b0;
            wr_req_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_port_q  <= grant_port_d;
            grant_is_wr_q <= grant_is_wr_d;
            last_port_q   <= last_port_d;
            rd_req_q      <= rd_req_d;
            wr_req_q      <= wr_req_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold until finish, one dead cycle after.
    always_comb begin
        state_d       = state_q;
        grant_port_d  = grant_port_q;
        grant_is_wr_d = grant_is_wr_q;
        last_port_d   = last_port_q;
        rd_req_d      = rd_req_q;
        wr_req_d      = wr_req_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d       = GRANT;
                    grant_port_d  = pick_port;
                    grant_is_wr_d = pick_is_wr;
                    last_port_d   = pick_port;
                    wr_req_d      = pick_is_wr;
                    rd_req_d      = !pick_is_wr;
                end
            end
            GRANT: begin
                if (grant_done) begin
                    state_d  = RELEASE;
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                end
            end
            RELEASE: begin
                // Requester drops its req now; do not let the stale level re-arbitrate.
                state_d  = IDLE;
                rd_req_d = 1'b0;
                wr_req_d = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                rd_req_d = 1'b0;
                wr_req_d = 1'b0;
            end
        endcase
    end

    // Moore outputs of the grant FSM.
    always_comb begin
        busy_int = (state_q == GRANT);
    end

    assign busy         = busy_int;
    assign grant_port   = grant_port_q;
    assign rd_burst_req = rd_req_q;
    assign wr_burst_req = wr_req_q;

    // Downstream request fields follow the registered grant with no added latency.
    assign rd_burst_addr = (grant_port_q == PORT1) ? p1_rd_burst_addr : p0_rd_burst_addr;
    assign rd_burst_len  = (grant_port_q == PORT1) ? p1_rd_burst_len  : p0_rd_burst_len;
    assign wr_burst_addr = (grant_port_q == PORT1) ? p1_wr_burst_addr : p0_wr_burst_addr;
    assign wr_burst_len  = (grant_port_q == PORT1) ? p1_wr_burst_len  : p0_wr_burst_len;
    assign wr_burst_data = (grant_port_q == PORT1) ? p1_wr_burst_data : p0_wr_burst_data;

    // Per-port return selects: granted port and matching direction only.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sel
        logic port_hit;
        assign port_hit   = (gi == 1) ? (grant_port_q == PORT1) : (grant_port_q == PORT0);
        assign rd_sel[gi] = busy_int && !grant_is_wr_q && port_hit;
        assign wr_sel[gi] = busy_int &&  grant_is_wr_q && port_hit;
    end

    // Return routing: strobes and finish pulses reach the granted port only.
    always_comb begin
        p0_rd_burst_data_valid = rd_burst_data_valid & rd_sel[0];
        p0_rd_burst_finish     = rd_burst_finish     & rd_sel[0];
        p0_wr_burst_data_req   = wr_burst_data_req   & wr_sel[0];
        p0_wr_burst_finish     = wr_burst_finish     & wr_sel[0];
        p1_rd_burst_data_valid = rd_burst_data_valid & rd_sel[1];
        p1_rd_burst_finish     = rd_burst_finish     & rd_sel[1];
        p1_wr_burst_data_req   = wr_burst_data_req   & wr_sel[1];
        p1_wr_burst_finish     = wr_burst_finish     & wr_sel[1];
    end

    // Read data is broadcast; the valid strobe tells the owner apart.
    assign p0_rd_burst_data = rd_burst_data;
    assign p1_rd_burst_data = rd_burst_data;

endmodule

// File: doc/mem_burst_arbiter.md
# mem_burst_arbiter

Two-port arbiter in the `mem_clk` domain that shares the single burst interface of the DDR3 burst adapter between two independent requesters, such as the memory tester and a second DMA-style client. Each requester sees an identical read/write burst interface. The arbiter grants one whole burst at a time, round-robin between ports, and steers address, length, data and finish signals to and from the granted port. It sits between the requesters and the burst adapter, which drives the MIG user interface.

## Interface
- `MEM_DATA_BITS`, default 512: burst data width.
- `ADDR_BITS`, default 28: burst address width.
- `LEN_BITS`, default 10: burst length width.
- `mem_clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `p0_rd_burst_req` / `p1_rd_burst_req` input 1: read burst request; held high until the matching finish pulse.
- `p0_wr_burst_req` / `p1_wr_burst_req` input 1: write burst request; held high until the matching finish pulse.
- `pN_rd_burst_len` / `pN_wr_burst_len` input LEN_BITS: burst length in beats.
- `pN_rd_burst_addr` / `pN_wr_burst_addr` input ADDR_BITS: burst start address.
- `pN_wr_burst_data` input MEM_DATA_BITS: write data for the port.
- `pN_wr_burst_data_req` output 1: write-data request, forwarded to the granted port only.
- `pN_rd_burst_data_valid` output 1: read-data valid, forwarded to the granted port only.
- `pN_rd_burst_data` output MEM_DATA_BITS: read data, broadcast to both ports.
- `pN_rd_burst_finish` / `pN_wr_burst_finish` output 1: one-cycle finish pulse to the granted port.
- `rd_burst_req`, `wr_burst_req`, `rd_burst_len`, `wr_burst_len`, `rd_burst_addr`, `wr_burst_addr`, `wr_burst_data` output: downstream copies of the selected port's signals.
- `rd_burst_data_valid`, `wr_burst_data_req`, `rd_burst_data`, `rd_burst_finish`, `wr_burst_finish` input: downstream returns from the burst adapter.
- `grant_port` output 1: index of the granted port; valid while `busy` is high.
- `busy` output 1: high while a burst is granted.

## Operation
- State machine with three states:
  - IDLE: no burst granted.
  - GRANT: burst in progress.
  - RELEASE: one cycle after a finish.
- IDLE → GRANT when any of the four requests is high.
  - Port choice is round-robin: the port other than `last_port` wins if it requests; otherwise the requesting port wins.
  - Within a port, write beats read when both are high.
  - Latch `grant_port`, `grant_is_wr` and `last_port` ← granted port.
- GRANT:
  - Downstream `wr_burst_req` or `rd_burst_req` (per `grant_is_wr`) is held high, registered.
  - Addr, len and wr_data are muxed combinationally from the granted port.
  - The other downstream req is 0.
- GRANT → RELEASE on the downstream finish matching `grant_is_wr`.
  - A non-matching finish is ignored.
- RELEASE:
  - Both downstream reqs are 0.
  - The requester drops its req in this cycle.
  - Go to IDLE unconditionally.
- Return routing:
  - `wr_burst_data_req`, `rd_burst_data_valid` and the finish pulses are ANDed with the grant select.
  - The non-granted port sees 0 on all of them.
- A granted requester dropping its req early does not abort the burst; the arbiter still waits for the finish.
- Reset values: state IDLE; `last_port` = 1, so port 0 wins first; `busy` 0; `grant_port` 0; all downstream reqs 0; all port-side valid/req/finish outputs 0.
- `rst` asserted mid-burst returns the arbiter to IDLE on the next edge with all reqs low. The burst adapter is reset by the same `rst`.

## Timing
- Request high at edge t in IDLE: `busy` and the downstream req are high from t+1. Arbitration latency is 1 cycle.
- Data paths are combinational through the registered grant, adding 0 cycles of latency.
  - The wr_data presentation contract of the burst adapter is unchanged.
- Downstream finish at cycle f:
  - The port finish pulses in cycle f.
  - Downstream req and `busy` are low at f+1.
  - IDLE at f+2.
  - The next grant is visible at f+3 at the earliest.
- Simultaneous requests from both ports in IDLE are resolved by the round-robin rule in the same cycle.

## Configuration
- With `MEM_ARB_FIXED_PRIO_EN` defined, port 0 always wins when requesting, and `last_port` is unused.
- Without it, round-robin applies as described.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/GRANT/RELEASE) and the port-index typedef.
- Sub-module `mem_arb_pick`: combinational next-port selector, taking the four reqs and `last_port` and returning port and is_wr. This selector is the only place the macro is tested.

## Test plan
- Port 0 writes len 64 to addr 0x100 alone:
  - Downstream `wr_burst_req` goes high 1 cycle later, with addr 0x100 and len 64.
  - 64 `p0_wr_burst_data_req` pulses reach port 0; `p1` sees none.
  - The finish pulse reaches `p0` only.
- Both ports request writes at the same edge after reset: port 0 is granted first; port 1 is granted at f+3.
- Port 1 requests rd and wr together: the write is granted first; after it finishes, the read is granted, unless port 0 is waiting.
- Port 0 issues back-to-back reads while port 1 requests continuously: grants alternate 0, 1, 0, 1 without starvation.
  - With `MEM_ARB_FIXED_PRIO_EN`, port 0 wins every time.
- `rst` asserted in the middle of a 256-beat read: all outputs are 0 next cycle, state IDLE; the first grant after reset goes to port 0.
- A spurious `rd_burst_finish` during a write grant: no port sees a finish, and the grant is held until `wr_burst_finish`.
